// File: rtl/ddr_stream_writer.sv
// Buffers a 16-bit word stream and writes it to one DDR arbiter client port.
// Aligned word pairs merge into 32-bit writes; other words go out as 16-bit writes.
module ddr_stream_writer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [24:1] start_addr,
    input  logic [15:0] word_count,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        active,
    output logic        done,
    output logic [24:1] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  mem_wr,
    output logic        mem_16b,
    input  logic        mem_busy,
    output logic [2:0]  dbg_state
);

    // Stream handshake: a word transfers on every rising clk edge where
    // s_valid && s_ready; s_data must be held while s_valid is high and
    // s_ready is low. s_ready does not depend on s_valid.

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [AW:0]   OCC_FULL = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]   OCC_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   OCC_TWO  = OCC_ONE + OCC_ONE;
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [15:0]   CNT_ONE  = 16'd1;
    localparam logic [15:0]   CNT_TWO  = 16'd2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;

    logic [2:0]    state;
    logic [24:1]   cur_addr;
    logic [15:0]   acc_cnt;
    logic [15:0]   wr_cnt;
    logic          is32;

    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   occ;

    logic          push;
    logic          in_select;
    logic          sel32;
    logic          sel16;
    logic [AW:0]   push_amt;
    logic [AW:0]   pop_amt;
    logic [AW:0]   occ_next;
    logic [15:0]   rd0;
    logic [15:0]   rd1;

    assign s_ready   = active && (acc_cnt != 16'd0) && (occ != OCC_FULL);
    assign push      = s_valid && s_ready;
    assign rd0       = fifo_mem[rptr];
    assign rd1       = fifo_mem[rptr + PTR_ONE];
    assign dbg_state = state;

    // An aligned address with more than one word left always waits for a pair.
    always_comb begin
        in_select = (state == S_SELECT) && (wr_cnt != 16'd0);
        sel32     = in_select && !cur_addr[1] && (wr_cnt >= CNT_TWO) && (occ >= OCC_TWO);
        sel16     = in_select && !sel32 && (cur_addr[1] || (wr_cnt == CNT_ONE))
                    && (occ >= OCC_ONE);
        push_amt  = push ? OCC_ONE : '0;
        pop_amt   = sel32 ? OCC_TWO : (sel16 ? OCC_ONE : '0);
        occ_next  = occ + push_amt - pop_amt;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            occ <= occ_next;
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (sel32) begin
                rptr <= rptr + PTR_ONE + PTR_ONE;
            end else if (sel16) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cur_addr <= '0;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            is32     <= 1'b0;
            active   <= 1'b0;
            done     <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_wr   <= '0;
            mem_16b  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) begin
                acc_cnt <= acc_cnt - CNT_ONE;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_addr <= start_addr;
                        acc_cnt  <= word_count;
                        wr_cnt   <= word_count;
                        if (word_count == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            active <= 1'b1;
                            state  <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    if (wr_cnt == 16'd0) begin
                        done   <= 1'b1;
                        active <= 1'b0;
                        state  <= S_IDLE;
                    end else if (sel32) begin
                        mem_addr <= cur_addr;
                        mem_din  <= {rd0, rd1};
                        mem_wr   <= 4'b1111;
                        mem_16b  <= 1'b0;
                        is32     <= 1'b1;
                        state    <= S_ISSUE;
                    end else if (sel16) begin
                        mem_addr <= cur_addr;
                        mem_din  <= {16'h0000, rd0};
                        mem_wr   <= 4'b0011;
                        mem_16b  <= 1'b1;
                        is32     <= 1'b0;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The arbiter latches on the rising edge of mem_wr, so it drops here.
                    mem_wr   <= 4'b0000;
                    cur_addr <= cur_addr + (is32 ? 24'd2 : 24'd1);
                    wr_cnt   <= wr_cnt - (is32 ? CNT_TWO : CNT_ONE);
                    state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!mem_busy) begin
                        state <= S_SELECT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_stream_writer.sv
// Directed bench for ddr_stream_writer: table of transfers with hand-computed
// writes, plus sequences for stall, backpressure, zero count, restart and reset.
module tb_ddr_stream_writer;

    typedef struct {
        logic [24:1]       addr;
        logic [15:0]       count;
        int                busy;
        logic [3:0][15:0]  words;
        int                n_exp;
        logic [2:0][60:0]  exp;
    } tv_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [24:1] start_addr;
    logic [15:0] word_count;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        active;
    logic        done;
    logic [24:1] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_wr;
    logic        mem_16b;
    logic        mem_busy;
    logic [2:0]  dbg_state;

    logic [15:0] src_q[$];
    logic [60:0] exp_q[$];

    int total = 0;
    int bad = 0;
    int accepted = 0;
    int stall_at = -1;
    int stall_len = 0;
    int stall_cnt = 0;
    int busy_len = 3;
    int busy_override = -1;
    int busy_cnt = 0;
    int wr_seen = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_wr_cyc = -1;

    tv_t tv[4];

    ddr_stream_writer #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .word_count(word_count), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .active(active), .done(done), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_wr(mem_wr), .mem_16b(mem_16b),
        .mem_busy(mem_busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout got=running need=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [60:0] mk(logic [24:1] a, logic [31:0] d, logic [3:0] w, logic b);
        return {a, d, w, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h need=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // producer driver
    initial begin
        s_valid = 1'b0;
        s_data  = 16'h0;
        forever begin
            @(negedge clk);
            if (stall_cnt > 0) begin
                stall_cnt--;
                s_valid = 1'b0;
            end else if (src_q.size() > 0) begin
                s_valid = 1'b1;
                s_data  = src_q[0];
            end else begin
                s_valid = 1'b0;
            end
            #4;
            if (s_valid && s_ready && !rst && src_q.size() > 0) begin
                void'(src_q.pop_front());
                accepted++;
                if (accepted == stall_at) stall_cnt = stall_len;
            end
        end
    end

    // arbiter model and write scoreboard
    initial begin
        logic [3:0]  prev_wr;
        logic        prev_done;
        logic [60:0] rec;
        logic [60:0] e;
        prev_wr   = 4'h0;
        prev_done = 1'b0;
        mem_busy  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_wr != 4'h0) begin
                chk("wr_pulse_width", {60'd0, prev_wr}, 64'd0);
                if (prev_wr == 4'h0) begin
                    rec = {mem_addr, mem_din, mem_wr, mem_16b};
                    chk("wr_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("wr_addr", {40'd0, rec[60:37]}, {40'd0, e[60:37]});
                        chk("wr_din", {32'd0, rec[36:5]}, {32'd0, e[36:5]});
                        chk("wr_mask", {60'd0, rec[4:1]}, {60'd0, e[4:1]});
                        chk("wr_16b", {63'd0, rec[0]}, {63'd0, e[0]});
                    end
                    if (last_wr_cyc >= 0) chk("wr_gap", {63'd0, (cyc - last_wr_cyc) >= 4}, 64'd1);
                    last_wr_cyc = cyc;
                    wr_seen++;
                    mem_busy = 1'b1;
                    if (busy_override >= 0) begin
                        busy_cnt = busy_override;
                        busy_override = -1;
                    end else begin
                        busy_cnt = busy_len;
                    end
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) mem_busy = 1'b0;
            end
            if (done) begin
                done_cnt++;
                chk("done_active_low", {63'd0, active}, 64'd0);
                chk("done_width", {63'd0, prev_done}, 64'd0);
            end
            prev_wr   = mem_wr;
            prev_done = done;
        end
    end

    task automatic pulse_start(input logic [24:1] a, input logic [15:0] n);
        tick();
        start      = 1'b1;
        start_addr = a;
        word_count = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 3000) begin
            tick();
            n++;
        end
        chk({name, "_done_seen"}, {63'd0, done_cnt != d0}, 64'd1);
    endtask

    task automatic wait_wr(input string name, input int w0);
        int n = 0;
        while (wr_seen == w0 && n < 1000) begin
            tick();
            n++;
        end
        chk({name, "_wr_seen"}, {63'd0, wr_seen != w0}, 64'd1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_s_ready"}, {63'd0, s_ready}, 64'd0);
        chk({name, "_active"}, {63'd0, active}, 64'd0);
        chk({name, "_done"}, {63'd0, done}, 64'd0);
        chk({name, "_mem_addr"}, {40'd0, mem_addr}, 64'd0);
        chk({name, "_mem_din"}, {32'd0, mem_din}, 64'd0);
        chk({name, "_mem_wr"}, {60'd0, mem_wr}, 64'd0);
        chk({name, "_mem_16b"}, {63'd0, mem_16b}, 64'd0);
    endtask

    // stimulus and checks
    initial begin
        int d0;
        int w0;
        int a0;
        int n;

        tv[0].addr = 24'h000100; tv[0].count = 16'd4; tv[0].busy = 5;
        tv[0].words = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        tv[0].n_exp = 2;
        tv[0].exp = {61'd0, mk(24'h000102, 32'h33334444, 4'hF, 1'b0),
                     mk(24'h000100, 32'h11112222, 4'hF, 1'b0)};
        tv[1].addr = 24'h000101; tv[1].count = 16'd4; tv[1].busy = 2;
        tv[1].words = {16'h8888, 16'h7777, 16'h6666, 16'h5555};
        tv[1].n_exp = 3;
        tv[1].exp = {mk(24'h000104, 32'h00008888, 4'h3, 1'b1),
                     mk(24'h000102, 32'h66667777, 4'hF, 1'b0),
                     mk(24'h000101, 32'h00005555, 4'h3, 1'b1)};
        tv[2].addr = 24'hFFFFFF; tv[2].count = 16'd3; tv[2].busy = 1;
        tv[2].words = {16'h0000, 16'hA003, 16'hA002, 16'hA001};
        tv[2].n_exp = 2;
        tv[2].exp = {61'd0, mk(24'h000000, 32'hA002A003, 4'hF, 1'b0),
                     mk(24'hFFFFFF, 32'h0000A001, 4'h3, 1'b1)};
        tv[3].addr = 24'h000010; tv[3].count = 16'd1; tv[3].busy = 4;
        tv[3].words = {16'h0000, 16'h0000, 16'h0000, 16'hB001};
        tv[3].n_exp = 1;
        tv[3].exp = {61'd0, 61'd0, mk(24'h000010, 32'h0000B001, 4'h3, 1'b1)};

        rst = 1'b1;
        start = 1'b0;
        start_addr = '0;
        word_count = '0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < int'(tv[i].count); k++) src_q.push_back(tv[i].words[k]);
            for (int k = 0; k < tv[i].n_exp; k++) exp_q.push_back(tv[i].exp[k]);
            busy_len = tv[i].busy;
            d0 = done_cnt;
            w0 = wr_seen;
            pulse_start(tv[i].addr, tv[i].count);
            chk("vec_active", {63'd0, active}, 64'd1);
            wait_done("vec", d0);
            chk("vec_writes", wr_seen - w0, tv[i].n_exp);
            chk("vec_exp_left", exp_q.size(), 0);
            chk("vec_src_left", src_q.size(), 0);
            repeat (2) tick();
        end

        // producer stall on the second word of an aligned pair
        busy_len = 3;
        src_q.push_back(16'hE001);
        src_q.push_back(16'hE002);
        exp_q.push_back(mk(24'h000020, 32'hE001E002, 4'hF, 1'b0));
        stall_at = accepted + 1;
        stall_len = 20;
        d0 = done_cnt;
        w0 = wr_seen;
        a0 = accepted;
        pulse_start(24'h000020, 16'd2);
        n = 0;
        while (accepted == a0 && n < 100) begin
            tick();
            n++;
        end
        repeat (15) tick();
        chk("stall_no_write", wr_seen - w0, 0);
        wait_done("stall", d0);
        chk("stall_writes", wr_seen - w0, 1);
        stall_at = -1;

        // backpressure: first write held busy for 100 cycles
        for (int k = 0; k < 16; k++) src_q.push_back(16'hD000 + 16'(k));
        for (int k = 0; k < 8; k++)
            exp_q.push_back(mk(24'h001000 + 24'(2 * k), {16'hD000 + 16'(2 * k), 16'hD001 + 16'(2 * k)},
                               4'hF, 1'b0));
        busy_override = 100;
        busy_len = 3;
        d0 = done_cnt;
        w0 = wr_seen;
        a0 = accepted;
        pulse_start(24'h001000, 16'd16);
        wait_wr("bp_first", w0);
        repeat (40) tick();
        chk("bp_s_ready_full", {63'd0, s_ready}, 64'd0);
        chk("bp_accepted", accepted - a0, 10);
        wait_done("bp", d0);
        chk("bp_writes", wr_seen - w0, 8);
        chk("bp_exp_left", exp_q.size(), 0);
        chk("bp_src_left", src_q.size(), 0);

        // zero count
        repeat (2) tick();
        d0 = done_cnt;
        w0 = wr_seen;
        pulse_start(24'h000050, 16'd0);
        chk("zero_done", {63'd0, done}, 64'd1);
        chk("zero_active", {63'd0, active}, 64'd0);
        tick();
        chk("zero_done_end", {63'd0, done}, 64'd0);
        repeat (5) tick();
        chk("zero_no_write", wr_seen - w0, 0);
        chk("zero_done_count", done_cnt - d0, 1);

        // start while active is ignored
        busy_len = 6;
        for (int k = 0; k < 4; k++) src_q.push_back(16'hC101 + 16'(k));
        exp_q.push_back(mk(24'h000300, 32'hC101C102, 4'hF, 1'b0));
        exp_q.push_back(mk(24'h000302, 32'hC103C104, 4'hF, 1'b0));
        d0 = done_cnt;
        w0 = wr_seen;
        pulse_start(24'h000300, 16'd4);
        repeat (3) tick();
        pulse_start(24'h000500, 16'd2);
        wait_done("restart", d0);
        repeat (10) tick();
        chk("restart_writes", wr_seen - w0, 2);
        chk("restart_done_count", done_cnt - d0, 1);
        chk("restart_exp_left", exp_q.size(), 0);

        // reset while waiting on busy
        busy_len = 20;
        for (int k = 0; k < 6; k++) src_q.push_back(16'hF001 + 16'(k));
        exp_q.push_back(mk(24'h000400, 32'hF001F002, 4'hF, 1'b0));
        w0 = wr_seen;
        pulse_start(24'h000400, 16'd6);
        wait_wr("rst_first", w0);
        repeat (3) tick();
        rst = 1'b1;
        src_q.delete();
        tick();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        chk("midrst_exp_left", exp_q.size(), 0);
        n = 0;
        while (mem_busy && n < 100) begin
            tick();
            n++;
        end
        chk("midrst_busy_clear", {63'd0, mem_busy}, 64'd0);
        busy_len = 3;
        src_q.push_back(16'hC001);
        src_q.push_back(16'hC002);
        exp_q.push_back(mk(24'h000200, 32'hC001C002, 4'hF, 1'b0));
        d0 = done_cnt;
        w0 = wr_seen;
        pulse_start(24'h000200, 16'd2);
        wait_done("post_rst", d0);
        chk("post_rst_writes", wr_seen - w0, 1);
        chk("post_rst_exp_left", exp_q.size(), 0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
